// File: rtl/audio_pkg.sv
// Shared encodings for the sound-effect scheduler: FSM/source codes, win states, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_pkg;

  // FSM state encoding; doubles as the active_src output code.
  typedef enum logic [1:0] {
    ST_MUSIC      = 2'd0,
    ST_PLAY_PUNCH = 2'd1,
    ST_PLAY_JUMP  = 2'd2,
    ST_MUTE       = 2'd3
  } sfx_state_e;

  localparam logic [1:0] SRC_MUSIC = 2'd0;
  localparam logic [1:0] SRC_PUNCH = 2'd1;
  localparam logic [1:0] SRC_JUMP  = 2'd2;
  localparam logic [1:0] SRC_MUTE  = 2'd3;

  // Game-state codes meaning a player has won the match (audio muted).
  localparam logic [1:0] WIN_P1 = 2'b01;
  localparam logic [1:0] WIN_P2 = 2'b10;

  localparam int unsigned DEFAULT_HEALTH_THRESHOLD = 154;

  function automatic logic is_win_state(input logic [1:0] s);
    return (s == WIN_P1) || (s == WIN_P2);
  endfunction

endpackage

// File: rtl/sfx_scheduler_req_edge.sv
// Button level -> one-shot request: level register, rise detect, sticky pend flag.
// Latency: rise is combinational vs. the registered level; pend visible 1 cycle after the rise.
// Backpressure: none; pend stays set until the scheduler clears or flushes it.
module sfx_req_edge
  import audio_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic lvl,      // raw button level
  input  logic clr,      // grant: drop the pending request
  input  logic consume,  // rise handled directly by the scheduler, do not latch it
  input  logic flush,    // mute/disable: drop everything, including a fresh rise
  output logic rise,
  output logic pend
);

  logic lvl_q, lvl_d;
  logic pend_q, pend_d;

  // Rise detect and pend update; a new rise beats a same-cycle grant clear.
  always_comb begin
    lvl_d = lvl;
    rise  = lvl & ~lvl_q;
    if (flush) begin
      pend_d = 1'b0;
    end else begin
      pend_d = (rise & ~consume) | (pend_q & ~clr);
    end
  end

  // Level and pend registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/sfx_scheduler.sv
// Arbitrates the 1-bit audio pin between music and timed punch/jump effects.
// Latency: audio_out/sfx_active/active_src register the FSM-selected source, 1 cycle behind the FSM.
// Backpressure: none; requests are edge-captured and held as pend flags until granted.
module sfx_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned HEALTH_THRESHOLD = DEFAULT_HEALTH_THRESHOLD,
  parameter int unsigned PUNCH_LEN        = 25_000_000,
  parameter int unsigned JUMP_LEN         = 15_000_000,
  parameter int unsigned CNT_W            = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_audio,
  input  logic [1:0] state,
  input  logic [1:0] attack_1,
  input  logic [1:0] attack_2,
  input  logic       jump_1,
  input  logic       jump_2,
  input  logic [8:0] player1_health,
  input  logic [8:0] player2_health,
  input  logic       bgm_in,
  input  logic       critical_in,
  input  logic       punch_in,
  input  logic       jump_in,
  output logic       audio_out,
  output logic       sfx_active,
  output logic [1:0] active_src
);

  localparam logic [CNT_W-1:0] PUNCH_RELOAD = CNT_W'(PUNCH_LEN - 1);
  localparam logic [CNT_W-1:0] JUMP_RELOAD  = CNT_W'(JUMP_LEN - 1);
  localparam logic [8:0]       HEALTH_TH    = 9'(HEALTH_THRESHOLD);

  sfx_state_e       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             audio_q, audio_d;
  logic             sfx_q, sfx_d;
  logic [1:0]       src_q, src_d;

  logic punch_lvl, jump_lvl;
  logic punch_rise, jump_rise;
  logic punch_pend, jump_pend;
  logic punch_clr, jump_clr;
  logic punch_consume, jump_consume;
  logic flush;
  logic critical;

  assign punch_lvl = (|attack_1) | (|attack_2);
  assign jump_lvl  = jump_1 | jump_2;

  sfx_req_edge u_punch_req (
    .clk     (clk),
    .reset   (reset),
    .lvl     (punch_lvl),
    .clr     (punch_clr),
    .consume (punch_consume),
    .flush   (flush),
    .rise    (punch_rise),
    .pend    (punch_pend)
  );

  sfx_req_edge u_jump_req (
    .clk     (clk),
    .reset   (reset),
    .lvl     (jump_lvl),
    .clr     (jump_clr),
    .consume (jump_consume),
    .flush   (flush),
    .rise    (jump_rise),
    .pend    (jump_pend)
  );

  // Next state and duration counter: disable, then mute, then per-state playback policy.
  always_comb begin
    fsm_d         = fsm_q;
    cnt_d         = cnt_q;
    punch_clr     = 1'b0;
    jump_clr      = 1'b0;
    punch_consume = 1'b0;
    jump_consume  = 1'b0;
    flush         = 1'b0;
    if (!enable_audio) begin
      fsm_d = ST_MUSIC;
      cnt_d = '0;
      flush = 1'b1;
    end else if (is_win_state(state)) begin
      fsm_d = ST_MUTE;
      cnt_d = '0;
      flush = 1'b1;
    end else begin
      case (fsm_q)
        ST_MUSIC: begin
          if (punch_pend) begin
            fsm_d     = ST_PLAY_PUNCH;
            cnt_d     = PUNCH_RELOAD;
            punch_clr = 1'b1;
          end else if (jump_pend) begin
            fsm_d    = ST_PLAY_JUMP;
            cnt_d    = JUMP_RELOAD;
            jump_clr = 1'b1;
          end
        end
        ST_PLAY_PUNCH: begin
          // A punch rise here retriggers the running punch instead of queueing another.
          punch_consume = 1'b1;
          if (punch_rise) begin
            cnt_d = PUNCH_RELOAD;
          end else if (cnt_q == '0) begin
            fsm_d = ST_MUSIC;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_PLAY_JUMP: begin
          // Punch pre-empts; the interrupted jump is dropped, never resumed.
          punch_consume = 1'b1;
          jump_consume  = 1'b1;
          if (punch_rise) begin
            fsm_d = ST_PLAY_PUNCH;
            cnt_d = PUNCH_RELOAD;
          end else if (jump_rise) begin
            cnt_d = JUMP_RELOAD;
          end else if (cnt_q == '0) begin
            fsm_d = ST_MUSIC;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          fsm_d = ST_MUSIC;
        end
      endcase
    end
  end

  // Source mux from the current state; disable forces silence immediately.
  always_comb begin
    critical = (player1_health <= HEALTH_TH) || (player2_health <= HEALTH_TH);
    audio_d  = 1'b0;
    sfx_d    = 1'b0;
    src_d    = SRC_MUTE;
    if (enable_audio) begin
      src_d = fsm_q;
      case (fsm_q)
        ST_MUSIC:      audio_d = critical ? critical_in : bgm_in;
        ST_PLAY_PUNCH: begin audio_d = punch_in; sfx_d = 1'b1; end
        ST_PLAY_JUMP:  begin audio_d = jump_in;  sfx_d = 1'b1; end
        default:       audio_d = 1'b0;
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= ST_MUSIC;
      cnt_q   <= '0;
      audio_q <= 1'b0;
      sfx_q   <= 1'b0;
      src_q   <= SRC_MUSIC;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      audio_q <= audio_d;
      sfx_q   <= sfx_d;
      src_q   <= src_d;
    end
  end

  assign audio_out  = audio_q;
  assign sfx_active = sfx_q;
  assign active_src = src_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Scoreboard bench for sfx_scheduler: reference model pushes per-cycle expectations.
// Latency: expectations are for the outputs registered at the following clock edge.
// Backpressure: n/a.
module tb_sfx_scheduler;

  localparam int PL = 8;
  localparam int JL = 5;
  localparam int TH = 154;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_audio;
  logic [1:0] state;
  logic [1:0] attack_1, attack_2;
  logic       jump_1, jump_2;
  logic [8:0] player1_health, player2_health;
  logic       bgm_in, critical_in, punch_in, jump_in;
  logic       audio_out, sfx_active;
  logic [1:0] active_src;

  always #5 clk = ~clk;

  sfx_scheduler #(
    .HEALTH_THRESHOLD(TH),
    .PUNCH_LEN       (PL),
    .JUMP_LEN        (JL),
    .CNT_W           (25)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_audio  (enable_audio),
    .state         (state),
    .attack_1      (attack_1),
    .attack_2      (attack_2),
    .jump_1        (jump_1),
    .jump_2        (jump_2),
    .player1_health(player1_health),
    .player2_health(player2_health),
    .bgm_in        (bgm_in),
    .critical_in   (critical_in),
    .punch_in      (punch_in),
    .jump_in       (jump_in),
    .audio_out     (audio_out),
    .sfx_active    (sfx_active),
    .active_src    (active_src)
  );

  typedef struct {
    logic       a;
    logic       s;
    logic [1:0] src;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt_p, cnt_j;

  // Reference model: mode 0 music, 1 punch, 2 jump, 3 mute; m_rem = effect cycles left.
  int m_mode = 0;
  int m_rem  = 0;
  bit m_pp = 0, m_pj = 0, m_pl = 0, m_jl = 0;

  task automatic model_step();
    bit   pl, jl, pr, jr, crit, win;
    exp_t e;
    pl = (|attack_1) || (|attack_2);
    jl = jump_1 || jump_2;
    pr = pl && !m_pl;
    jr = jl && !m_jl;
    if (reset) begin
      m_mode = 0; m_rem = 0; m_pp = 0; m_pj = 0; m_pl = 0; m_jl = 0;
      e.a = 1'b0; e.s = 1'b0; e.src = 2'd0;
      exp_q.push_back(e);
      return;
    end
    crit = (int'(player1_health) <= TH) || (int'(player2_health) <= TH);
    win  = (state == 2'd1) || (state == 2'd2);
    if (!enable_audio) begin
      e.a = 1'b0; e.s = 1'b0; e.src = 2'd3;
    end else begin
      e.src = 2'(m_mode);
      e.s   = (m_mode == 1) || (m_mode == 2);
      case (m_mode)
        0:       e.a = crit ? critical_in : bgm_in;
        1:       e.a = punch_in;
        2:       e.a = jump_in;
        default: e.a = 1'b0;
      endcase
    end
    if (!enable_audio) begin
      m_mode = 0; m_rem = 0; m_pp = 0; m_pj = 0;
    end else if (win) begin
      m_mode = 3; m_rem = 0; m_pp = 0; m_pj = 0;
    end else begin
      case (m_mode)
        0: begin
          if (m_pp) begin m_mode = 1; m_rem = PL; m_pp = 0; end
          else if (m_pj) begin m_mode = 2; m_rem = JL; m_pj = 0; end
          if (pr) m_pp = 1;
          if (jr) m_pj = 1;
        end
        1: begin
          if (pr) m_rem = PL;
          else if (m_rem == 1) m_mode = 0;
          else m_rem--;
          if (jr) m_pj = 1;
        end
        2: begin
          if (pr) begin m_mode = 1; m_rem = PL; end
          else if (jr) m_rem = JL;
          else if (m_rem == 1) m_mode = 0;
          else m_rem--;
        end
        default: begin
          m_mode = 0;
          if (pr) m_pp = 1;
          if (jr) m_pj = 1;
        end
      endcase
    end
    m_pl = pl;
    m_jl = jl;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per clock edge, compared 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_underflow t=%0t: no expectation queued", $time);
    end else begin
      mon_e = exp_q.pop_front();
      if (audio_out !== mon_e.a || sfx_active !== mon_e.s || active_src !== mon_e.src) begin
        n_errors++;
        $display("FAIL outputs t=%0t: got audio=%b sfx=%b src=%0d, want audio=%b sfx=%b src=%0d",
                 $time, audio_out, sfx_active, active_src, mon_e.a, mon_e.s, mon_e.src);
      end
    end
  end

  task automatic check_cnt(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_errors++;
      $display("FAIL %s: got %0d cycles, want %0d", name, act, want);
    end
  endtask

  // One clock: randomize tones, push model expectation, advance, tally visible source.
  task automatic step();
    bgm_in      = 1'($urandom);
    critical_in = 1'($urandom);
    punch_in    = 1'($urandom);
    jump_in     = 1'($urandom);
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (active_src == 2'd1) cnt_p++;
    if (active_src == 2'd2) cnt_j++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_all();
    attack_1 = 2'b00; attack_2 = 2'b00; jump_1 = 1'b0; jump_2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable_audio = 1'b1; state = 2'b00;
    release_all();
    player1_health = 9'd300; player2_health = 9'd300;
    steps(3);
    reset = 1'b0;
    steps(10);

    // Held punch button: exactly one PL-cycle effect.
    cnt_p = 0; cnt_j = 0;
    attack_1 = 2'b01;
    steps(20);
    release_all();
    steps(8);
    check_cnt("held_punch_len", cnt_p, PL);
    check_cnt("held_punch_no_jump", cnt_j, 0);

    // Jump truncated by a punch rise two cycles in, then not replayed.
    cnt_p = 0; cnt_j = 0;
    jump_1 = 1'b1;
    steps(3);
    attack_2 = 2'b10;
    steps(20);
    release_all();
    steps(6);
    check_cnt("preempt_jump_len", cnt_j, 2);
    check_cnt("preempt_punch_len", cnt_p, PL);

    // Simultaneous rises: full punch then full jump.
    cnt_p = 0; cnt_j = 0;
    attack_1 = 2'b11; jump_2 = 1'b1;
    steps(25);
    release_all();
    steps(4);
    check_cnt("simul_punch_len", cnt_p, PL);
    check_cnt("simul_jump_len", cnt_j, JL);

    // Health threshold boundary.
    player2_health = 9'd154; steps(6);
    player2_health = 9'd155; steps(6);
    player1_health = 9'd0;   steps(4);
    player1_health = 9'd300; steps(2);

    // Mute mid-punch, then recover.
    attack_1 = 2'b10; steps(4);
    state = 2'b10; steps(3);
    state = 2'b00; steps(4);
    release_all(); steps(12);

    // Disable mid-effect.
    jump_1 = 1'b1; steps(4);
    enable_audio = 1'b0; steps(3);
    enable_audio = 1'b1; release_all(); steps(6);

    // Reset mid-effect.
    attack_2 = 2'b01; steps(5);
    reset = 1'b1; steps(1);
    reset = 1'b0; steps(4);
    release_all(); steps(6);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(9) == 0)  attack_1 = 2'($urandom);
      if ($urandom_range(13) == 0) attack_2 = 2'($urandom);
      if ($urandom_range(8) == 0)  jump_1 = ~jump_1;
      if ($urandom_range(14) == 0) jump_2 = ~jump_2;
      if (state != 2'b00) begin
        if ($urandom_range(3) == 0) state = 2'b00;
      end else if ($urandom_range(119) == 0) begin
        state = 2'($urandom);
      end
      if (!enable_audio) enable_audio = ($urandom_range(2) == 0);
      else if ($urandom_range(199) == 0) enable_audio = 1'b0;
      if ($urandom_range(49) == 0) begin
        case ($urandom_range(5))
          0: player1_health = 9'd153;
          1: player1_health = 9'd154;
          2: player1_health = 9'd155;
          3: player1_health = 9'd0;
          default: player1_health = 9'($urandom);
        endcase
        player2_health = ($urandom_range(1) == 0) ? 9'd300 : 9'($urandom_range(150, 160));
      end
      reset = ($urandom_range(499) == 0);
      step();
    end
    reset = 1'b0;
    steps(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
